uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares the single UART TX FIFO write port among NUM_REQ byte-stream requesters
//   (e.g. test-string generator, SPI echo, UART RX echo), so that only one block
//   drives tx_fifo_write_en/tx_fifo_data_in. Round-robin, packet-locked arbitration
//   with FIFO-full backpressure. Sits between the requesters and the uart instance.
// PARAMETERS
//   NUM_REQ       3    number of requesters (1..8)
//   MAX_BURST     16   max bytes per grant before forced re-arbitration (1..255)
//   IDLE_TIMEOUT  255  cycles a granted requester may hold req_valid low mid-packet before release (1..255)
// PORTS
//   clock            in   1          system clock (27 MHz)
//   reset            in   1          asynchronous, active-high reset
//   req_valid        in   NUM_REQ    requester i has a byte on req_data[i*8+:8]
//   req_data         in   8*NUM_REQ  packed bytes, requester i at [i*8+7:i*8]
//   req_last         in   NUM_REQ    byte offered by requester i is its packet's last
//   req_ready        out  NUM_REQ    byte accepted from requester i this cycle (combinational)
//   tx_fifo_full     in   1          UART TX FIFO cannot accept a write this cycle
//   tx_fifo_data_in  out  8          byte to UART TX FIFO (registered)
//   tx_fifo_write_en out  1          single-cycle write strobe (registered)
//   grant            out  NUM_REQ    one-hot current owner, all-zero when idle (registered)
//   busy             out  1          arbiter is in SEND
// BEHAVIOUR
//   Reset (async assert, sync deassert use): state=IDLE, grant=0, busy=0, req_ready=0,
//     tx_fifo_write_en=0, tx_fifo_data_in=8'h00, last_owner=NUM_REQ-1, counters=0.
//   States: IDLE, SEND.
//   IDLE: if any req_valid, pick first set bit searching last_owner+1, +2, ... (wrap mod
//     NUM_REQ); next cycle state=SEND, grant=one-hot(winner), busy=1, burst_cnt=0, idle_cnt=0.
//     No bytes accepted in IDLE (req_ready=0). Arbitration latency: 1 cycle.
//   SEND (owner g): req_ready[g] = req_valid[g] & ~tx_fifo_full; other req_ready bits = 0.
//     Transfer = req_valid[g] & req_ready[g]. On transfer: tx_fifo_data_in <= req_data[g],
//     tx_fifo_write_en <= 1 for exactly one cycle (1-cycle latency), burst_cnt++, idle_cnt=0.
//   Release (-> IDLE next cycle, grant=0, busy=0, last_owner=g) when any of:
//     transfer with req_last[g]=1; transfer making burst_cnt==MAX_BURST;
//     idle_cnt reaches IDLE_TIMEOUT (idle_cnt counts cycles with req_valid[g]=0;
//     cycles stalled by tx_fifo_full with req_valid[g]=1 do NOT count).
//   Back-to-back: at most one byte per cycle; a requester may stream one byte/cycle while
//     FIFO not full. Re-grant to same requester after release only if no other valid
//     (round-robin guarantees fairness: each waiting requester served within NUM_REQ grants).
//   tx_fifo_full asserted: no write, req_ready=0, data held; grant held indefinitely.
//   Simultaneous requests in IDLE: round-robin order from last_owner+1 decides; first after
//     reset is requester 0.
//   req_valid dropping in IDLE before grant: winner chosen from valid bits of that cycle only.
//   NUM_REQ=1: degenerates to pass-through with 1-cycle IDLE gap per packet/burst.
//   Reset mid-packet: all outputs return to reset values immediately; partial packet abandoned,
//     no further strobe issued.
//   Widths: burst_cnt, idle_cnt 8-bit, saturate-free (release occurs at limit); grant index
//     $clog2(NUM_REQ) bits, wrap via explicit compare to NUM_REQ-1, not power-of-two mask.
// TESTING
//   1 single req0 sends "Test\r\n" (last on 8'h0A), FIFO never full -> 6 strobes, bytes
//     54 65 73 74 0D 0A, consecutive cycles, grant=001 then 000 one cycle after last.
//   2 req0,req1,req2 all valid from reset, 2-byte packets each -> grant order 0,1,2,0...;
//     no strobe in the 1-cycle IDLE gaps; never two bits of grant set.
//   3 req1 streams 20 bytes no last, MAX_BURST=16, req2 waiting -> 16 strobes, release,
//     req2 granted, then req1 regains for remaining 4.
//   4 tx_fifo_full held high 10 cycles mid-packet -> req_ready=0, write_en=0 for 10 cycles,
//     no timeout, transfer resumes cycle after full drops with same byte, no loss/duplicate.
//   5 owner drops req_valid mid-packet for IDLE_TIMEOUT cycles -> release on that cycle count,
//     next requester granted; 5-cycle gap (<timeout) keeps grant.
//   6 reset asserted during SEND -> write_en, grant, busy, req_ready go 0 same cycle (async);
//     after deassert first grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing the UART TX FIFO write port among
// NUM_REQ byte-stream requesters, with burst limit, idle timeout and FIFO-full backpressure.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned IDLE_TIMEOUT = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 tx_fifo_full,
    output logic [7:0]           tx_fifo_data_in,
    output logic                 tx_fifo_write_en,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int unsigned   IW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);
    localparam logic [7:0]    BURST_LIMIT = 8'(MAX_BURST);
    localparam logic [7:0]    IDLE_LIMIT  = 8'(IDLE_TIMEOUT);

    typedef enum logic {IDLE, SEND} state_t;

    state_t               state, state_nxt;
    logic [IW-1:0]        owner, owner_nxt;
    logic [IW-1:0]        last_owner, last_owner_nxt;
    logic [IW-1:0]        winner, cand;
    logic                 found;
    logic [7:0]           burst_cnt, burst_nxt;
    logic [7:0]           idle_cnt, idle_nxt;
    logic [7:0]           data_nxt;
    logic                 we_nxt;
    logic [NUM_REQ-1:0]   grant_nxt;
    logic [7:0]           req_byte [NUM_REQ];
    logic                 owner_valid, owner_last, transfer;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_byte[i] = req_data[i*8 +: 8];
        end
    end

    // Search starts one past the previous owner and wraps by explicit compare.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = last_owner;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
            if (!found && req_valid[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign owner_valid = req_valid[owner];
    assign owner_last  = req_last[owner];
    assign transfer    = (state == SEND) && owner_valid && !tx_fifo_full;
    assign req_ready   = transfer ? grant : '0;
    assign busy        = (state == SEND);

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_owner_nxt = last_owner;
        grant_nxt      = grant;
        burst_nxt      = burst_cnt;
        idle_nxt       = idle_cnt;
        data_nxt       = tx_fifo_data_in;
        we_nxt         = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = SEND;
                    owner_nxt = winner;
                    grant_nxt = NUM_REQ'(1) << winner;
                    burst_nxt = '0;
                    idle_nxt  = '0;
                end
            end
            SEND: begin
                if (transfer) begin
                    we_nxt    = 1'b1;
                    data_nxt  = req_byte[owner];
                    burst_nxt = burst_cnt + 8'd1;
                    idle_nxt  = '0;
                    if (owner_last || (burst_cnt + 8'd1 == BURST_LIMIT)) begin
                        state_nxt      = IDLE;
                        grant_nxt      = '0;
                        last_owner_nxt = owner;
                    end
                end else if (!owner_valid) begin
                    // Stalls with the owner still valid do not advance the timeout.
                    idle_nxt = idle_cnt + 8'd1;
                    if (idle_cnt + 8'd1 == IDLE_LIMIT) begin
                        state_nxt      = IDLE;
                        grant_nxt      = '0;
                        last_owner_nxt = owner;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            owner            <= '0;
            last_owner       <= LAST_IDX;
            grant            <= '0;
            burst_cnt        <= '0;
            idle_cnt         <= '0;
            tx_fifo_data_in  <= '0;
            tx_fifo_write_en <= 1'b0;
        end else begin
            state            <= state_nxt;
            owner            <= owner_nxt;
            last_owner       <= last_owner_nxt;
            grant            <= grant_nxt;
            burst_cnt        <= burst_nxt;
            idle_cnt         <= idle_nxt;
            tx_fifo_data_in  <= data_nxt;
            tx_fifo_write_en <= we_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: cycle-level behavioural model plus
// directed scenarios with literal expectations and a randomized phase.
module tb_uart_tx_arbiter;

    localparam int N  = 3;
    localparam int MB = 16;
    localparam int TO = 12;

    logic           clock = 1'b0;
    logic           rst   = 1'b1;
    logic [N-1:0]   rv    = '0;
    logic [8*N-1:0] rd    = '0;
    logic [N-1:0]   rl    = '0;
    logic           full  = 1'b0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_fifo_data_in;
    logic           tx_fifo_write_en;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clock = ~clock;

    uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .IDLE_TIMEOUT(TO)) dut (
        .clock            (clock),
        .reset            (rst),
        .req_valid        (rv),
        .req_data         (rd),
        .req_last         (rl),
        .req_ready        (req_ready),
        .tx_fifo_full     (full),
        .tx_fifo_data_in  (tx_fifo_data_in),
        .tx_fifo_write_en (tx_fifo_write_en),
        .grant            (grant),
        .busy             (busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner as an integer (-1 = nobody), rotation by modulo.
    int           m_owner = -1;
    int           m_last  = N - 1;
    int           m_burst = 0;
    int           m_idle  = 0;
    logic         m_we    = 1'b0;
    logic [7:0]   m_data  = 8'h00;
    int           tick    = 0;
    logic [N-1:0] prev_grant = '0;

    logic [7:0]   wr_log[$];
    int           wr_tick[$];
    logic [N-1:0] glog[$];
    int           gfall[$];
    logic [7:0]   exp_w[$];
    logic [N-1:0] exp_g[$];

    always @(negedge clock) begin
        logic [N-1:0] eg, er;
        tick++;
        if (rst) begin
            m_owner = -1; m_last = N - 1; m_burst = 0; m_idle = 0; m_we = 1'b0; m_data = 8'h00;
        end
        eg = (m_owner < 0) ? '0 : (N'(1) << m_owner);
        er = '0;
        if (m_owner >= 0 && rv[m_owner] && !full) er[m_owner] = 1'b1;
        chk("grant", grant, eg);
        chk("busy", busy, m_owner >= 0);
        chk("write_en", tx_fifo_write_en, m_we);
        chk("data", tx_fifo_data_in, m_data);
        chk("req_ready", req_ready, er);
        chk("grant_onehot", $countones(grant) <= 1, 1);
        if (tx_fifo_write_en) begin
            wr_log.push_back(tx_fifo_data_in);
            wr_tick.push_back(tick);
        end
        if (grant != '0 && prev_grant == '0) glog.push_back(grant);
        if (grant == '0 && prev_grant != '0) gfall.push_back(tick);
        prev_grant = grant;
        if (!rst) begin
            m_we = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    if (m_owner < 0 && rv[(m_last + k) % N]) begin
                        m_owner = (m_last + k) % N;
                        m_burst = 0;
                        m_idle  = 0;
                    end
                end
            end else if (rv[m_owner] && !full) begin
                m_we   = 1'b1;
                m_data = rd[m_owner*8 +: 8];
                m_burst++;
                m_idle = 0;
                if (rl[m_owner] || m_burst == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (!rv[m_owner]) begin
                m_idle++;
                if (m_idle == TO) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    end

    // Per-requester byte sources for the directed scenarios.
    logic [7:0] sd [N][32];
    logic       sl [N][32];
    int         slen [N];
    int         spos [N];
    int         gap_cnt [N];
    int         gap_req, gap_at, gap_len, full_start, full_len;

    task automatic push_byte(input int r, input logic [7:0] b, input logic last);
        sd[r][slen[r]] = b;
        sl[r][slen[r]] = last;
        slen[r]++;
    endtask

    task automatic push_pkt(input int r, input int n, input logic [7:0] base, input logic with_last);
        for (int k = 0; k < n; k++) push_byte(r, base + 8'(k), with_last && (k == n - 1));
    endtask

    task automatic do_reset();
        rst = 1'b1; rv = '0; rl = '0; rd = '0; full = 1'b0;
        @(posedge clock); #2;
        rst = 1'b0;
        wr_log.delete(); wr_tick.delete(); glog.delete(); gfall.delete();
        exp_w.delete(); exp_g.delete();
        for (int i = 0; i < N; i++) begin
            slen[i] = 0; spos[i] = 0; gap_cnt[i] = 0;
        end
        gap_req = -1; gap_at = 0; gap_len = 0; full_start = 0; full_len = 0;
    endtask

    task automatic run_streams(input int budget);
        int c = 0;
        bit done = 1'b0;
        while (!done && c < budget) begin
            done = 1'b1;
            for (int i = 0; i < N; i++) if (spos[i] < slen[i]) done = 1'b0;
            if (!done) begin
                for (int i = 0; i < N; i++) begin
                    if (spos[i] < slen[i]) begin
                        rd[i*8 +: 8] = sd[i][spos[i]];
                        rl[i]        = sl[i][spos[i]];
                    end else begin
                        rd[i*8 +: 8] = 8'h00;
                        rl[i]        = 1'b0;
                    end
                    if (gap_cnt[i] > 0) begin
                        rv[i] = 1'b0;
                        gap_cnt[i]--;
                    end else begin
                        rv[i] = (spos[i] < slen[i]);
                    end
                end
                full = (c >= full_start) && (c < full_start + full_len);
                @(negedge clock);
                for (int i = 0; i < N; i++) begin
                    if (req_ready[i]) begin
                        spos[i]++;
                        if (i == gap_req && spos[i] == gap_at) gap_cnt[i] = gap_len;
                    end
                end
                @(posedge clock); #2;
                c++;
            end
        end
        chk("stream_done", done, 1);
        rv = '0; rl = '0; rd = '0; full = 1'b0;
        repeat (3) begin @(posedge clock); #2; end
    endtask

    task automatic check_logs(input string tag);
        chk({tag, "_nbytes"}, wr_log.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++)
            chk({tag, "_byte"}, (i < wr_log.size()) ? 32'(wr_log[i]) : 32'hFFFF, 32'(exp_w[i]));
        chk({tag, "_ngrants"}, glog.size(), exp_g.size());
        for (int i = 0; i < exp_g.size(); i++)
            chk({tag, "_grant"}, (i < glog.size()) ? 32'(glog[i]) : 32'hFFFF, 32'(exp_g[i]));
    endtask

    initial begin
        int gaps [3];
        gaps = '{5, 11, 12};
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_write_en", tx_fifo_write_en, 0);
        chk("rst_data", tx_fifo_data_in, 0);
        chk("rst_ready", req_ready, 0);

        // "Test\r\n" from requester 0
        push_byte(0, 8'h54, 0); push_byte(0, 8'h65, 0); push_byte(0, 8'h73, 0);
        push_byte(0, 8'h74, 0); push_byte(0, 8'h0D, 0); push_byte(0, 8'h0A, 1);
        exp_w = '{8'h54, 8'h65, 8'h73, 8'h74, 8'h0D, 8'h0A};
        exp_g = '{3'b001};
        run_streams(60);
        check_logs("t1");
        if (wr_tick.size() == 6 && gfall.size() >= 1) begin
            chk("t1_consecutive", wr_tick[5] - wr_tick[0], 5);
            chk("t1_release_tick", gfall[0], wr_tick[5]);
        end else begin
            chk("t1_tick_logs", wr_tick.size(), 6);
        end

        // all three requesters, two 2-byte packets each
        do_reset();
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 2, 8'(16 * i), 1);
            push_pkt(i, 2, 8'(16 * i + 2), 1);
        end
        exp_w = '{8'h00, 8'h01, 8'h10, 8'h11, 8'h20, 8'h21, 8'h02, 8'h03, 8'h12, 8'h13, 8'h22, 8'h23};
        exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        run_streams(100);
        check_logs("t2");

        // burst limit: req1 streams 20 bytes while req2 waits
        do_reset();
        push_pkt(1, 20, 8'h10, 0);
        push_pkt(2, 2, 8'hA0, 1);
        for (int k = 0; k < 16; k++) exp_w.push_back(8'h10 + 8'(k));
        exp_w.push_back(8'hA0); exp_w.push_back(8'hA1);
        for (int k = 16; k < 20; k++) exp_w.push_back(8'h10 + 8'(k));
        exp_g = '{3'b010, 3'b100, 3'b010};
        run_streams(100);
        check_logs("t3");

        // FIFO full for 10 cycles mid-packet
        do_reset();
        push_pkt(0, 6, 8'h60, 1);
        push_pkt(1, 1, 8'h70, 1);
        full_start = 3; full_len = 10;
        exp_w = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h70};
        exp_g = '{3'b001, 3'b010};
        run_streams(80);
        check_logs("t4");
        if (wr_tick.size() >= 6) chk("t4_stall_span", wr_tick[5] - wr_tick[0], 15);
        else chk("t4_tick_logs", wr_tick.size(), 7);

        // owner gaps below and at the idle timeout
        foreach (gaps[g]) begin
            do_reset();
            push_pkt(0, 4, 8'h30, 1);
            push_pkt(1, 2, 8'h40, 1);
            gap_req = 0; gap_at = 2; gap_len = gaps[g];
            if (gaps[g] < TO) begin
                exp_w = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40, 8'h41};
                exp_g = '{3'b001, 3'b010};
            end else begin
                exp_w = '{8'h30, 8'h31, 8'h40, 8'h41, 8'h32, 8'h33};
                exp_g = '{3'b001, 3'b010, 3'b001};
            end
            run_streams(80);
            check_logs($sformatf("t5_gap%0d", gaps[g]));
        end

        // asynchronous reset during SEND
        do_reset();
        push_pkt(2, 1, 8'hEE, 1);
        run_streams(20);
        rv = 3'b001; rd = {16'h0000, 8'h55}; rl = '0;
        repeat (4) begin @(posedge clock); #2; end
        chk("t6_busy_before", busy, 1);
        chk("t6_we_before", tx_fifo_write_en, 1);
        rst = 1'b1;
        #1;
        chk("t6_async_we", tx_fifo_write_en, 0);
        chk("t6_async_grant", grant, 0);
        chk("t6_async_busy", busy, 0);
        chk("t6_async_ready", req_ready, 0);
        @(posedge clock); #2;
        rst = 1'b0;
        rv = 3'b111;
        glog.delete();
        repeat (3) begin @(posedge clock); #2; end
        chk("t6_first_grant", (glog.size() > 0) ? 32'(glog[0]) : 32'hFFFF, 1);

        // randomized traffic against the model
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            int dens;
            dens = $urandom_range(1, 9);
            for (int c = 0; c < 50; c++) begin
                for (int i = 0; i < N; i++) begin
                    rv[i] = ($urandom_range(0, 9) < dens);
                    rl[i] = ($urandom_range(0, 5) == 0);
                end
                rd   = 24'($urandom);
                full = ($urandom_range(0, 4) == 0);
                rst  = ($urandom_range(0, 149) == 0);
                @(posedge clock); #2;
            end
        end
        rst = 1'b0; rv = '0; full = 1'b0;
        repeat (TO + 4) begin @(posedge clock); #2; end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
